mips_decode_alu: RTL and testbench

//  Multi-cycle MIPS-I execute/control core: 5-step sequencer, main decoder, ALU-op decoder and 32-bit ALU in one block.

---
 rtl/mips_decode_alu.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_mips_decode_alu.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_alu.sv
// mips_decode_alu
//   Multi-cycle MIPS-I execute/control core. It contains the five-step
//   sequencer, the main decoder, the ALU-op decoder and a 32-bit ALU. It
//   drives every datapath select and strobe for the CPU top. Only the
//   sequencer state and `active` are registered. All other outputs are
//   combinational from state and instr.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | out of reset, waiting to start
//   FETCH | read instruction at PC (halts instead when pc_zero)
//   DECODE| latch instruction into IR
//   EXEC1 | ALU / address phase, data memory access for loads/stores
//   EXEC2 | write-back and PC update
//   HALTED| terminal until reset
//
// Ports
//   clk, reset (async, active-low), waitrequest (Avalon stall), pc_zero
//   instr, rs_data, rt_data        : instruction and register operands
//   state, active                  : sequencer status
//   alu_result, branch_taken       : ALU result / address, branch decision
//   mem_read, mem_write, pc_to_addr, instr_write, pc_write, reg_write : strobes
//   reg_dst, link, mem_to_reg, load_imm, hi_to_reg, lo_to_reg, jump,
//   reg_to_jump, md_en, md_signed, md_op, extend_op : selects
//
//   Destination register: reg_dst ? rd : (link ? $31 : rt). JALR sets
//   both reg_dst and link, so it writes PC+8 to rd.
//
// Configuration macro
//   ILLEGAL_INSTR_HALT_EN : when defined, an unknown instruction seen in
//   DECODE halts the core. When undefined, it executes as a NOP.

module mips_decode_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic        pc_zero,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [2:0]  state,
  output logic        active,
  output logic [31:0] alu_result,
  output logic        branch_taken,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_to_addr,
  output logic        instr_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        link,
  output logic        mem_to_reg,
  output logic        load_imm,
  output logic        hi_to_reg,
  output logic        lo_to_reg,
  output logic        jump,
  output logic        reg_to_jump,
  output logic        md_en,
  output logic        md_signed,
  output logic [1:0]  md_op,
  output logic [2:0]  extend_op
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  localparam logic [1:0] B_RT   = 2'd0;
  localparam logic [1:0] B_SEXT = 2'd1;
  localparam logic [1:0] B_ZEXT = 2'd2;

  state_t state_q, state_d;
  logic   active_q, active_d;

  logic [5:0]  opcode;
  logic [4:0]  rt_f;
  logic [4:0]  sa;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign opcode = instr[31:26];
  assign rt_f   = instr[20:16];
  assign sa     = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // The rs register number is resolved by the register file, not here.
  logic unused_rs_field;
  assign unused_rs_field = ^instr[25:21];

  // Decoded instruction attributes
  logic       d_legal, d_writes, d_load, d_store, d_var_shift;
  logic       d_reg_dst, d_link, d_mem_to_reg, d_load_imm, d_hi, d_lo;
  logic       d_jump, d_reg_to_jump, d_md, d_md_signed;
  logic [1:0] d_md_op, d_b_sel;
  logic [2:0] d_ext;
  alu_op_t    d_alu_op;

  always_comb begin
    d_legal       = 1'b0;
    d_writes      = 1'b0;
    d_load        = 1'b0;
    d_store       = 1'b0;
    d_var_shift   = 1'b0;
    d_reg_dst     = 1'b0;
    d_link        = 1'b0;
    d_mem_to_reg  = 1'b0;
    d_load_imm    = 1'b0;
    d_hi          = 1'b0;
    d_lo          = 1'b0;
    d_jump        = 1'b0;
    d_reg_to_jump = 1'b0;
    d_md          = 1'b0;
    d_md_signed   = 1'b0;
    d_md_op       = 2'd0;
    d_b_sel       = B_RT;
    d_ext         = 3'd0;
    d_alu_op      = ALU_NONE;
    case (opcode)
      6'h00: begin
        d_reg_dst = 1'b1;
        case (funct)
          6'h00: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_SLL; end
          6'h02: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_SRL; end
          6'h03: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_SRA; end
          6'h04: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_SLL; d_var_shift = 1'b1; end
          6'h06: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_SRL; d_var_shift = 1'b1; end
          6'h07: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_SRA; d_var_shift = 1'b1; end
          6'h08: begin d_legal = 1'b1; d_jump = 1'b1; d_reg_to_jump = 1'b1; end
          6'h09: begin
            d_legal = 1'b1; d_writes = 1'b1; d_link = 1'b1;
            d_jump = 1'b1; d_reg_to_jump = 1'b1;
          end
          6'h10: begin d_legal = 1'b1; d_writes = 1'b1; d_hi = 1'b1; end
          6'h12: begin d_legal = 1'b1; d_writes = 1'b1; d_lo = 1'b1; end
          6'h11: begin d_legal = 1'b1; d_md = 1'b1; d_md_op = 2'd2; end
          6'h13: begin d_legal = 1'b1; d_md = 1'b1; d_md_op = 2'd3; end
          6'h18: begin d_legal = 1'b1; d_md = 1'b1; d_md_op = 2'd0; d_md_signed = 1'b1; end
          6'h19: begin d_legal = 1'b1; d_md = 1'b1; d_md_op = 2'd0; end
          6'h1A: begin d_legal = 1'b1; d_md = 1'b1; d_md_op = 2'd1; d_md_signed = 1'b1; end
          6'h1B: begin d_legal = 1'b1; d_md = 1'b1; d_md_op = 2'd1; end
          6'h21: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_ADD; end
          6'h23: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_SUB; end
          6'h24: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_AND; end
          6'h25: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_OR; end
          6'h26: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_XOR; end
          6'h2A: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_SLT; end
          6'h2B: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_SLTU; end
          default: d_reg_dst = 1'b0;
        endcase
      end
      6'h01: begin
        case (rt_f)
          5'd0, 5'd1:   d_legal = 1'b1;
          5'd16, 5'd17: begin d_legal = 1'b1; d_writes = 1'b1; d_link = 1'b1; end
          default: ;
        endcase
      end
      6'h02: begin d_legal = 1'b1; d_jump = 1'b1; end
      6'h03: begin d_legal = 1'b1; d_jump = 1'b1; d_link = 1'b1; d_writes = 1'b1; end
      6'h04, 6'h05: begin d_legal = 1'b1; d_alu_op = ALU_SUB; end
      6'h06, 6'h07: d_legal = 1'b1;
      6'h09: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_ADD;  d_b_sel = B_SEXT; end
      6'h0A: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_SLT;  d_b_sel = B_SEXT; end
      6'h0B: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_SLTU; d_b_sel = B_SEXT; end
      6'h0C: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_AND;  d_b_sel = B_ZEXT; end
      6'h0D: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_OR;   d_b_sel = B_ZEXT; end
      6'h0E: begin d_legal = 1'b1; d_writes = 1'b1; d_alu_op = ALU_XOR;  d_b_sel = B_ZEXT; end
      6'h0F: begin d_legal = 1'b1; d_writes = 1'b1; d_load_imm = 1'b1; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        d_legal = 1'b1; d_writes = 1'b1; d_load = 1'b1;
        d_alu_op = ALU_ADD; d_b_sel = B_SEXT;
        case (opcode)
          6'h20:   d_ext = 3'd7;
          6'h21:   d_ext = 3'd5;
          6'h24:   d_ext = 3'd6;
          6'h25:   d_ext = 3'd4;
          default: d_mem_to_reg = 1'b1;
        endcase
      end
      6'h28, 6'h29, 6'h2B: begin
        d_legal = 1'b1; d_store = 1'b1; d_alu_op = ALU_ADD; d_b_sel = B_SEXT;
      end
      default: ;
    endcase
  end

  // Branch condition, compared directly on the register operands
  logic br_cond;
  always_comb begin
    br_cond = 1'b0;
    case (opcode)
      6'h01: begin
        case (rt_f)
          5'd0, 5'd16: br_cond = rs_data[31];
          5'd1, 5'd17: br_cond = ~rs_data[31];
          default:     br_cond = 1'b0;
        endcase
      end
      6'h04:   br_cond = (rs_data == rt_data);
      6'h05:   br_cond = (rs_data != rt_data);
      6'h06:   br_cond = rs_data[31] | (rs_data == 32'd0);
      6'h07:   br_cond = ~rs_data[31] & (rs_data != 32'd0);
      default: br_cond = 1'b0;
    endcase
  end

  // ALU
  logic [31:0] alu_b;
  logic [4:0]  shamt;
  logic [31:0] alu_y;

  always_comb begin
    case (d_b_sel)
      B_SEXT:  alu_b = {{16{imm[15]}}, imm};
      B_ZEXT:  alu_b = {16'd0, imm};
      default: alu_b = rt_data;
    endcase
    shamt = d_var_shift ? rs_data[4:0] : sa;
    case (d_alu_op)
      ALU_ADD:  alu_y = rs_data + alu_b;
      ALU_SUB:  alu_y = rs_data - alu_b;
      ALU_AND:  alu_y = rs_data & alu_b;
      ALU_OR:   alu_y = rs_data | alu_b;
      ALU_XOR:  alu_y = rs_data ^ alu_b;
      ALU_SLT:  alu_y = {31'd0, ($signed(rs_data) < $signed(alu_b))};
      ALU_SLTU: alu_y = {31'd0, (rs_data < alu_b)};
      ALU_SLL:  alu_y = rt_data << shamt;
      ALU_SRL:  alu_y = rt_data >> shamt;
      ALU_SRA:  alu_y = $unsigned($signed(rt_data) >>> shamt);
      default:  alu_y = 32'd0;
    endcase
  end

  assign alu_result = alu_y;

  // Sequencer
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    if (!waitrequest) begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_FETCH;
          active_d = 1'b1;
        end
        S_FETCH: begin
          if (pc_zero) begin
            state_d  = S_HALTED;
            active_d = 1'b0;
          end else begin
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          state_d = S_EXEC1;
`ifdef ILLEGAL_INSTR_HALT_EN
          if (!d_legal) begin
            state_d  = S_HALTED;
            active_d = 1'b0;
          end
`endif
        end
        S_EXEC1:  state_d = S_EXEC2;
        S_EXEC2:  state_d = S_FETCH;
        S_HALTED: state_d = S_HALTED;
        default: begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end
      endcase
    end
  end

`ifdef ILLEGAL_INSTR_HALT_EN
`else
  // Without the halt option an unknown instruction simply decodes to no
  // attributes, so the legality flag has no consumer.
  logic unused_legal;
  assign unused_legal = d_legal;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  assign state  = state_q;
  assign active = active_q;

  // Strobes and selects. Write-back and jump selects are meaningful only
  // in EXEC2, where the register/PC writes happen.
  logic in_ex2;
  assign in_ex2 = (state_q == S_EXEC2);

  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    pc_to_addr   = 1'b0;
    instr_write  = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    md_en        = 1'b0;
    case (state_q)
      S_FETCH: begin
        pc_to_addr = ~pc_zero;
        mem_read   = ~pc_zero;
      end
      S_DECODE: instr_write = 1'b1;
      S_EXEC1: begin
        mem_read  = d_load;
        mem_write = d_store;
      end
      S_EXEC2: begin
        pc_write  = ~waitrequest;
        reg_write = d_writes & ~waitrequest;
        md_en     = d_md & ~waitrequest;
      end
      default: ;
    endcase
  end

  assign branch_taken = br_cond & ((state_q == S_EXEC1) | in_ex2);
  assign reg_dst      = in_ex2 & d_reg_dst;
  assign link         = in_ex2 & d_link;
  assign mem_to_reg   = in_ex2 & d_mem_to_reg;
  assign load_imm     = in_ex2 & d_load_imm;
  assign hi_to_reg    = in_ex2 & d_hi;
  assign lo_to_reg    = in_ex2 & d_lo;
  assign jump         = in_ex2 & d_jump;
  assign reg_to_jump  = in_ex2 & d_reg_to_jump;
  assign md_signed    = in_ex2 & d_md_signed;
  assign md_op        = in_ex2 ? d_md_op : 2'd0;
  assign extend_op    = in_ex2 ? d_ext : 3'd0;

endmodule

// File: tb/tb_mips_decode_alu.sv
module tb_mips_decode_alu;

  logic        clk = 1'b0;
  logic        reset, waitrequest, pc_zero;
  logic [31:0] instr, rs_data, rt_data;
  logic [2:0]  state;
  logic        active, branch_taken;
  logic [31:0] alu_result;
  logic        mem_read, mem_write, pc_to_addr, instr_write, pc_write, reg_write;
  logic        reg_dst, link, mem_to_reg, load_imm, hi_to_reg, lo_to_reg;
  logic        jump, reg_to_jump, md_en, md_signed;
  logic [1:0]  md_op;
  logic [2:0]  extend_op;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_decode_alu dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .pc_zero(pc_zero),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .state(state), .active(active), .alu_result(alu_result),
    .branch_taken(branch_taken), .mem_read(mem_read), .mem_write(mem_write),
    .pc_to_addr(pc_to_addr), .instr_write(instr_write), .pc_write(pc_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .link(link),
    .mem_to_reg(mem_to_reg), .load_imm(load_imm), .hi_to_reg(hi_to_reg),
    .lo_to_reg(lo_to_reg), .jump(jump), .reg_to_jump(reg_to_jump),
    .md_en(md_en), .md_signed(md_signed), .md_op(md_op), .extend_op(extend_op)
  );

  // {mem_read, mem_write, pc_to_addr, instr_write, pc_write, reg_write}
  logic [5:0] strb;
  assign strb = {mem_read, mem_write, pc_to_addr, instr_write, pc_write, reg_write};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; waitrequest = 1'b0; pc_zero = 1'b0;
    instr = 32'h0000_0021; rs_data = 32'h7FFF_FFFF; rt_data = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_strobes", {26'd0, strb}, 32'd0);

    reset = 1'b1;
    step();
    chk("seq_fetch", {29'd0, state}, 32'd1);
    chk("seq_active", {31'd0, active}, 32'd1);
    chk("fetch_strobes", {26'd0, strb}, 32'b101000);
    step();
    chk("seq_decode", {29'd0, state}, 32'd2);
    chk("decode_strobes", {26'd0, strb}, 32'b000100);
    step();
    chk("seq_exec1", {29'd0, state}, 32'd3);
    chk("addu_result", alu_result, 32'h8000_0000);
    chk("addu_ex1_regwr", {31'd0, reg_write}, 32'd0);
    chk("addu_ex1_regdst", {31'd0, reg_dst}, 32'd0);
    step();
    chk("seq_exec2", {29'd0, state}, 32'd4);
    chk("addu_ex2_strobes", {26'd0, strb}, 32'b000011);
    chk("addu_ex2_regdst", {31'd0, reg_dst}, 32'd1);
    step();
    chk("seq_fetch2", {29'd0, state}, 32'd1);
    chk("fetch2_regdst", {31'd0, reg_dst}, 32'd0);

    // Combinational ALU vectors
    instr = 32'h2C00_FFFF; rs_data = 32'd5; #1;
    chk("sltiu", alu_result, 32'd1);
    instr = 32'h0000_002A; rs_data = 32'hFFFF_FFFF; rt_data = 32'd1; #1;
    chk("slt", alu_result, 32'd1);
    instr = 32'h0000_002B; #1;
    chk("sltu", alu_result, 32'd0);
    instr = 32'h0000_0103; rt_data = 32'h8000_0000; #1;
    chk("sra", alu_result, 32'hF800_0000);
    instr = 32'h0000_0006; rs_data = 32'd4; #1;
    chk("srlv", alu_result, 32'h0800_0000);
    instr = 32'h3000_FFFF; rs_data = 32'hFFFF_1234; #1;
    chk("andi", alu_result, 32'h0000_1234);
    instr = 32'h0000_0023; rs_data = 32'd0; rt_data = 32'd1; #1;
    chk("subu", alu_result, 32'hFFFF_FFFF);

    // Stall in FETCH
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_state", {29'd0, state}, 32'd1);
      chk("stall_memrd", {31'd0, mem_read}, 32'd1);
      chk("stall_pcwr", {31'd0, pc_write}, 32'd0);
    end
    waitrequest = 1'b0;

    // BGEZAL rs=0
    instr = 32'h0411_0000; rs_data = 32'd0;
    step();
    chk("bgezal_decode", {29'd0, state}, 32'd2);
    step();
    chk("bgezal_ex1_taken", {31'd0, branch_taken}, 32'd1);
    step();
    chk("bgezal_ex2_taken", {31'd0, branch_taken}, 32'd1);
    chk("bgezal_link", {31'd0, link}, 32'd1);
    chk("bgezal_regwr", {31'd0, reg_write}, 32'd1);
    chk("bgezal_regdst", {31'd0, reg_dst}, 32'd0);

    // BNE a=b=3
    step();
    instr = 32'h1400_0000; rs_data = 32'd3; rt_data = 32'd3;
    step(); step();
    chk("bne_taken", {31'd0, branch_taken}, 32'd0);
    step();
    chk("bne_ex2_strobes", {26'd0, strb}, 32'b000010);
    instr = 32'h1000_0000; #1;
    chk("beq_taken", {31'd0, branch_taken}, 32'd1);

    // LW with stall in EXEC2
    step();
    instr = 32'h8C00_0004; rs_data = 32'h0000_0100; #1;
    chk("lw_addr", alu_result, 32'h0000_0104);
    step(); step();
    chk("lw_ex1_strobes", {26'd0, strb}, 32'b100000);
    step();
    waitrequest = 1'b1; #1;
    chk("lw_stall_strobes", {26'd0, strb}, 32'b000000);
    chk("lw_mem_to_reg", {31'd0, mem_to_reg}, 32'd1);
    chk("lw_extend", {29'd0, extend_op}, 32'd0);
    step();
    chk("lw_stall_state", {29'd0, state}, 32'd4);
    waitrequest = 1'b0; #1;
    chk("lw_ex2_strobes", {26'd0, strb}, 32'b000011);

    // Unknown opcode executes as NOP
    step();
    instr = 32'hFC00_0000;
    step(); step();
    chk("nop_ex1_strobes", {26'd0, strb}, 32'd0);
    step();
    chk("nop_ex2_strobes", {26'd0, strb}, 32'b000010);

    // Halt on pc_zero
    step();
    pc_zero = 1'b1;
    step();
    chk("halt_state", {29'd0, state}, 32'd5);
    chk("halt_active", {31'd0, active}, 32'd0);
    chk("halt_strobes", {26'd0, strb}, 32'd0);
    pc_zero = 1'b0;
    repeat (3) step();
    chk("halt_hold", {29'd0, state}, 32'd5);
    chk("halt_hold_strobes", {26'd0, strb}, 32'd0);

    // Reset out of HALTED, then reset in the middle of an instruction
    reset = 1'b0; #1;
    chk("rst2_state", {29'd0, state}, 32'd0);
    reset = 1'b1;
    step();
    chk("rst2_fetch", {29'd0, state}, 32'd1);
    instr = 32'h0000_0021;
    step(); step(); step();
    chk("mid_ex2", {29'd0, state}, 32'd4);
    reset = 1'b0; #1;
    chk("mid_rst_state", {29'd0, state}, 32'd0);
    chk("mid_rst_strobes", {26'd0, strb}, 32'd0);
    chk("mid_rst_regdst", {31'd0, reg_dst}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
